spike_count_classifier: RTL and testbench

Output-layer readout stage that sits directly downstream of the final neuron layer. It counts spikes from each output neuron over a programmable window of timesteps, then scans the counts sequentially to select the winning class (argmax). It presents the class index and its spike count with a one-cycle valid strobe.

---
 rtl/nn_classifier_pkg.sv | 7 +
 rtl/spike_count_classifier_if.sv | 21 ++
 rtl/spike_count_classifier_sat_counter.sv | 15 +
 rtl/spike_count_classifier.sv | 89 ++++++++
 tb/tb_spike_count_classifier.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/nn_classifier_pkg.sv
// nn_classifier_pkg: classifier FSM states and default sizing constants.
package nn_classifier_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  localparam int N_OUT_DEF = 10;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;
endpackage

// File: rtl/spike_count_classifier_if.sv
// spike_count_classifier_if: window control, spike input and class result bundle.
interface spike_count_classifier_if #(
  parameter int N_OUT = 10,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int IDX_W = $clog2(N_OUT)
);
  logic             start;
  logic             ce;
  logic [N_OUT-1:0] spikes_in;
  logic [WIN_W-1:0] window_len;
  logic             busy;
  logic             class_valid;
  logic [IDX_W-1:0] class_idx;
  logic [CNT_W-1:0] class_count;
  logic             tie;
  modport master (output start, ce, spikes_in, window_len,
                  input  busy, class_valid, class_idx, class_count, tie);
  modport slave  (input  start, ce, spikes_in, window_len,
                  output busy, class_valid, class_idx, class_count, tie);
endinterface

// File: rtl/spike_count_classifier_sat_counter.sv
// sat_counter: clearable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/spike_count_classifier.sv
// spike_count_classifier: windowed per-neuron spike counting and sequential argmax readout.
// Define SPIKE_CLASSIFIER_TIE_FLAG_EN to compute the tie flag; otherwise tie is tied to 0.
module spike_count_classifier
  import nn_classifier_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int IDX_W = $clog2(N_OUT)
) (
  input logic clk,
  input logic rst_n,
  spike_count_classifier_if.slave bus
);
  state_t           state, nxt;
  logic [WIN_W-1:0] win, ts;
  logic [CNT_W-1:0] cnt [N_OUT];
  logic [IDX_W-1:0] scan_idx, best_idx, nb_idx;
  logic [CNT_W-1:0] best_cnt, nb_cnt, cur;
  logic             clr, acc_ce, last_ce, last_idx, take, busy_d;
  assign clr      = state == IDLE && bus.start;
  assign acc_ce   = state == ACCUM && bus.ce;
  assign last_ce  = acc_ce && ts == win - 1'b1;
  assign last_idx = scan_idx == IDX_W'(N_OUT - 1);
  assign cur      = cnt[scan_idx];
  // index 0 always seeds the best; later entries replace it only when strictly greater
  assign take     = scan_idx == '0 || cur > best_cnt;
  assign nb_idx   = take ? scan_idx : best_idx;
  assign nb_cnt   = take ? cur : best_cnt;
  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .inc  (acc_ce && bus.spikes_in[g]),
      .q    (cnt[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (bus.start ? ACCUM : IDLE) :
          state == ACCUM ? (last_ce ? SCAN : ACCUM) :
          state == SCAN  ? (last_idx ? DONE : SCAN) : IDLE;
  always_comb busy_d = nxt == ACCUM || nxt == SCAN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win             <= '0;
      ts              <= '0;
      scan_idx        <= '0;
      best_idx        <= '0;
      best_cnt        <= '0;
      bus.busy        <= 1'b0;
      bus.class_valid <= 1'b0;
      bus.class_idx   <= '0;
      bus.class_count <= '0;
    end else begin
      bus.busy        <= busy_d;
      bus.class_valid <= state == SCAN && last_idx;
      if (clr) begin
        win <= bus.window_len == '0 ? WIN_W'(1) : bus.window_len;
        ts  <= '0;
      end else if (acc_ce) ts <= ts + 1'b1;
      if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        best_idx <= nb_idx;
        best_cnt <= nb_cnt;
      end else scan_idx <= '0;
      if (state == SCAN && last_idx) begin
        bus.class_idx   <= nb_idx;
        bus.class_count <= nb_cnt;
      end
    end
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
  logic best_tie, nb_tie;
  assign nb_tie = take ? 1'b0 : (cur == best_cnt ? 1'b1 : best_tie);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      best_tie <= 1'b0;
      bus.tie  <= 1'b0;
    end else begin
      if (state == SCAN) best_tie <= nb_tie;
      if (state == SCAN && last_idx) bus.tie <= nb_tie;
    end
`else
  assign bus.tie = 1'b0;
`endif
endmodule

// File: tb/tb_spike_count_classifier.sv
// tb_spike_count_classifier: directed windows checked every cycle against a timestep-level model.
module tb_spike_count_classifier;
  localparam int N = 10;
  localparam int MAXC = 255;
`ifdef SPIKE_CLASSIFIER_TIE_FLAG_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;

  spike_count_classifier_if #(.N_OUT(N), .CNT_W(8), .WIN_W(8)) bus ();
  spike_count_classifier_if #(.N_OUT(N), .CNT_W(8), .WIN_W(9)) b2 ();
  spike_count_classifier #(.N_OUT(N), .CNT_W(8), .WIN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  spike_count_classifier #(.N_OUT(N), .CNT_W(8), .WIN_W(9)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: tracks counts per timestep and schedules the result N cycles after the last ce.
  int  cyc = 0, due = 0, done_cyc = -10, win = 1, steps = 0;
  bit  acc = 0, pend = 0;
  int  m_c [N];
  bit  e_busy = 0, e_valid = 0, e_tie = 0;
  int  e_idx = 0, e_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = 0; pend = 0; e_busy = 0; e_valid = 0;
      e_idx = 0; e_cnt = 0; e_tie = 0; done_cyc = -10;
    end else begin
      cyc++;
      if (acc && bus.ce) begin
        for (int i = 0; i < N; i++) m_c[i] = (m_c[i] + int'(bus.spikes_in[i]) > MAXC) ? MAXC : m_c[i] + int'(bus.spikes_in[i]);
        steps++;
        if (steps == win) begin acc = 0; pend = 1; due = cyc + N; end
      end else if (!acc && !pend && cyc - 1 > done_cyc && bus.start) begin
        acc = 1; steps = 0;
        win = bus.window_len == 0 ? 1 : int'(bus.window_len);
        for (int i = 0; i < N; i++) m_c[i] = 0;
      end
      e_valid = pend && cyc == due;
      if (e_valid) begin
        e_idx = 0;
        for (int i = 1; i < N; i++) if (m_c[i] > m_c[e_idx]) e_idx = i;
        e_cnt = m_c[e_idx];
        e_tie = 0;
        if (TE) for (int j = 0; j < N; j++) if (j != e_idx && m_c[j] == e_cnt) e_tie = 1;
        pend = 0; done_cyc = cyc;
      end
      e_busy = acc || pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("class_valid", int'(bus.class_valid), int'(e_valid));
    chk("class_idx", int'(bus.class_idx), e_idx);
    chk("class_count", int'(bus.class_count), e_cnt);
    chk("tie", int'(bus.tie), int'(e_tie));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int wl, input logic [N-1:0] pa, input logic [N-1:0] pb, input int nce,
                     input int gap_at, input int gap_len, input bit poke, output int lat);
    bus.start = 1'b1; bus.window_len = wl[7:0];
    tick;
    bus.start = poke;
    for (int i = 0; i < nce; i++) begin
      if (i == gap_at) begin bus.ce = 1'b0; repeat (gap_len) tick; end
      bus.ce = 1'b1; bus.spikes_in = (i % 2 == 1) ? pb : pa;
      tick;
    end
    bus.ce = 1'b0; bus.spikes_in = '0; lat = 1;
    while (!bus.class_valid && lat < 60) begin tick; lat++; end
    bus.start = 1'b0;
    chk("valid_seen", int'(bus.class_valid), 1);
    tick;
  endtask

  task automatic res(input string t, input int idx, input int cnt, input int tie);
    chk({t, "_idx"}, int'(bus.class_idx), idx);
    chk({t, "_count"}, int'(bus.class_count), cnt);
    chk({t, "_tie"}, int'(bus.tie), tie);
  endtask

  initial begin
    int lat;
    bus.start = 0; bus.ce = 0; bus.spikes_in = '0; bus.window_len = '0;
    b2.start = 0; b2.ce = 0; b2.spikes_in = '0; b2.window_len = '0;
    repeat (3) tick;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.class_valid), 0);
    res("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick;
    run(4, 10'h008, 10'h008, 4, -1, 0, 0, lat);
    chk("t1_latency", lat, 11);
    res("t1", 3, 4, 0);
    run(5, 10'h084, 10'h084, 5, -1, 0, 0, lat);
    res("t2", 2, 5, int'(TE));
    run(0, 10'h200, 10'h200, 1, -1, 0, 0, lat);
    res("t3_wl0", 9, 1, 0);
    run(255, 10'h200, 10'h200, 255, -1, 0, 0, lat);
    res("t3_wl255", 9, 255, 0);
    run(6, 10'h030, 10'h021, 6, -1, 0, 0, lat);
    res("t4_nogap", 5, 6, 0);
    run(6, 10'h030, 10'h021, 6, 3, 20, 0, lat);
    res("t4_gap", 5, 6, 0);
    run(3, 10'h002, 10'h002, 3, -1, 0, 1, lat);
    res("t5_poke", 1, 3, 0);
    run(3, 10'h000, 10'h000, 3, -1, 0, 0, lat);
    res("t_zero", 0, 0, int'(TE));
    run(3, 10'h002, 10'h002, 3, -1, 0, 0, lat);
    bus.start = 1'b1; bus.window_len = 8'd4;
    tick;
    bus.start = 1'b0;
    repeat (4) begin bus.ce = 1'b1; bus.spikes_in = 10'h010; tick; end
    bus.ce = 1'b0; bus.spikes_in = '0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_valid", int'(bus.class_valid), 0);
    res("t6_rst", 0, 0, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (15) tick;
    run(2, 10'h040, 10'h040, 2, -1, 0, 0, lat);
    res("t6_after", 6, 2, 0);
    b2.start = 1'b1; b2.window_len = 9'd300;
    tick;
    b2.start = 1'b0; b2.ce = 1'b1; b2.spikes_in = 10'h200;
    repeat (300) tick;
    b2.ce = 1'b0; b2.spikes_in = '0; lat = 1;
    while (!b2.class_valid && lat < 60) begin tick; lat++; end
    chk("t7_valid", int'(b2.class_valid), 1);
    chk("t7_latency", lat, 11);
    chk("t7_idx", int'(b2.class_idx), 9);
    chk("t7_count", int'(b2.class_count), 255);
    tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
